// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - debug read-out engine streaming a register-file address range
// Walks a spare combinational read port over [first_addr..last_addr] (wrapping) and emits (addr, data) words.
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_ra,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [ADDR_W-1:0] rf_ra_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;
  logic              done_q;

  // Span wraps modulo the file depth, so first > last walks through the top entry back to 0.
  logic [ADDR_W-1:0] span;
  logic [ADDR_W:0]   count;
  logic              load;

  assign span  = last_addr - first_addr;
  assign count = {1'b0, span} + ONE;
  assign load  = !out_valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      rf_ra_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        state_q     <= S_IDLE;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
        rf_ra_q     <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              ptr_q       <= first_addr;
              remaining_q <= count;
              rf_ra_q     <= first_addr;
              busy_q      <= 1'b1;
              state_q     <= S_RUN;
            end
          end
          S_RUN: begin
            if (load) begin
              out_data_q  <= rf_rd;
              out_addr_q  <= ptr_q;
              out_valid_q <= 1'b1;
              ptr_q       <= ptr_q + 1'b1;
              remaining_q <= remaining_q - ONE;
              if (remaining_q == ONE) begin
                rf_ra_q <= '0;
                state_q <= S_DRAIN;
              end else begin
                rf_ra_q <= ptr_q + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rf_ra     = rf_ra_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - self-checking bench for regfile_dump
// Table of dump ranges plus randomized ranges/backpressure, checked against a queue-based expectation.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic        abort = 1'b0;
  logic [4:0]  rf_ra;
  logic [31:0] rf_rd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;

  logic [31:0] mem [32];
  logic        pre = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  int total = 0;
  int bad = 0;

  regfile_dump #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .abort(abort), .rf_ra(rf_ra), .rf_rd(rf_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Register file model: clocked write port, combinational read port.
  assign rf_rd = mem[rf_ra];
  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         pct;
    int         ab;
    int         n;
  } vec_t;

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int pct,
                          input int ab, input int n, input bit wr);
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    int cyc, hs, busy_cnt, done_cnt, done_cyc, last_hs, stab_err, pi;
    bit fin, ab_sent, pv, pr, r;
    logic [4:0]  pa;
    logic [31:0] pd;
    for (int i = 0; i < n; i++) begin
      qa.push_back(5'((32'(f) + 32'(i)) % 32));
      qd.push_back(mem[5'((32'(f) + 32'(i)) % 32)]);
    end
    cyc = 0; hs = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -2;
    stab_err = 0; pi = 0; fin = 0; ab_sent = 0; pv = 0; pr = 0; pa = '0; pd = '0;
    first_addr = f; last_addr = l; start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_rf_ra", rf_ra, f);
    check("start_no_valid", out_valid, 0);
    if (wr) begin
      wr_en = 1'b1; wr_addr = f; wr_data = 32'hDEADBEEF;
    end
    while (!fin && cyc < 600) begin
      if (cyc == 1) wr_en = 1'b0;
      if (busy) busy_cnt++;
      if (pv && !pr && !(out_valid && out_addr == pa && out_data == pd)) stab_err++;
      if (done) begin
        done_cnt++; done_cyc = cyc; fin = 1;
      end else begin
        if (ab > 0 && hs == ab && !ab_sent) begin
          abort = 1'b1; ab_sent = 1; r = 0;
        end else if (pct < 0) begin
          r = (pi % 3 == 0); pi++;
        end else begin
          r = ($urandom_range(0, 99) < pct);
        end
        out_ready = r;
        pv = out_valid; pr = r; pa = out_addr; pd = out_data;
        if (out_valid && r) begin
          if (hs < n) begin
            check("word_addr", out_addr, qa[hs]);
            check("word_data", out_data, qd[hs]);
          end
          hs++; last_hs = cyc + 1;
        end
        @(posedge clk); #1;
        abort = 1'b0; cyc++;
        if (ab_sent) begin
          check("abort_valid", out_valid, 0);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          fin = 1;
        end
      end
    end
    out_ready = 1'b0;
    wr_en = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout: dump %0d..%0d never finished, handshakes=%0d want %0d", f, l, hs, n);
    end
    if (ab_sent) begin
      repeat (4) begin
        @(posedge clk); #1;
        if (done) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_hs_count", hs, ab);
      check("abort_idle", busy, 0);
    end else begin
      check("hs_count", hs, n);
      check("done_after_last_hs", done_cyc, last_hs);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
      if (pct == 100) begin
        check("done_latency", done_cyc, n + 1);
        check("busy_cycles", busy_cnt, n + 2);
      end
    end
    check("hold_stable", stab_err, 0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{first: 5'd0,  last: 5'd31, pct: 100, ab: 0, n: 32});
    vecs.push_back('{first: 5'd30, last: 5'd1,  pct: 100, ab: 0, n: 4});
    vecs.push_back('{first: 5'd4,  last: 5'd7,  pct: -1,  ab: 0, n: 4});
    vecs.push_back('{first: 5'd8,  last: 5'd15, pct: 100, ab: 2, n: 8});
    vecs.push_back('{first: 5'd3,  last: 5'd3,  pct: 100, ab: 0, n: 1});
    vecs.push_back('{first: 5'd31, last: 5'd30, pct: 100, ab: 0, n: 32});
    vecs.push_back('{first: 5'd17, last: 5'd17, pct: 30,  ab: 0, n: 1});
    vecs.push_back('{first: 5'd31, last: 5'd0,  pct: 100, ab: 0, n: 2});
    vecs.push_back('{first: 5'd12, last: 5'd20, pct: 40,  ab: 5, n: 9});

    // Reset held with start high: everything stays cleared.
    start = 1'b1; first_addr = 5'd7; last_addr = 5'd9; pre = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pre = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_addr", out_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_rf_ra", rf_ra, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);

    // Abort together with start in IDLE leaves the block idle.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy, 0);

    foreach (vecs[i]) run_dump(vecs[i].first, vecs[i].last, vecs[i].pct, vecs[i].ab, vecs[i].n, 1'b0);

    // Write on the load edge: old value emitted, new value on the next dump.
    run_dump(5'd5, 5'd5, 100, 0, 1, 1'b1);
    check("wr_new_value_in_file", mem[5], 32'hDEADBEEF);
    run_dump(5'd5, 5'd5, 100, 0, 1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      logic [4:0] f, l;
      f = 5'($urandom_range(0, 31));
      l = 5'($urandom_range(0, 31));
      run_dump(f, l, int'($urandom_range(20, 100)), 0, ((32'(l) - 32'(f)) & 32'd31) + 1, 1'b0);
    end

    // Asynchronous reset mid-dump clears outputs without waiting for an edge.
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rf_ra", rf_ra, 0);
    check("async_rst_data", out_data, 0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("after_async_rst_idle", busy, 0);
    run_dump(5'd2, 5'd4, 100, 0, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
